// File: rtl/muldiv_seq.sv
// muldiv_seq: sequencer for the multicycle multiply/divide path.
// Loads mult/div operands, waits the iteration count, commits Hi/Lo.
module muldiv_seq #(
   parameter int unsigned MULT_CYCLES = 32,
   parameter int unsigned DIV_CYCLES  = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] divisor,
   output logic        busy,
   output logic        done,
   output logic        div0,
   output logic        mult_ctrl,
   output logic        DIVASelect,
   output logic        DIVBSelect,
   output logic        RegAWrite,
   output logic        RegBWrite,
   output logic        MDSelect,
   output logic        HiCtrl,
   output logic        LoCtrl
);

   typedef enum logic [2:0] {
      IDLE, LOAD, RUN, WRITE, DONE, EXC
   } state_t;

   localparam logic [1:0] OP_MULT = 2'b00;
   localparam logic [1:0] OP_DIVM = 2'b10;
   localparam logic [1:0] OP_RSVD = 2'b11;
   localparam logic [7:0] MULT_LD = 8'(MULT_CYCLES - 1);
   localparam logic [7:0] DIV_LD  = 8'(DIV_CYCLES - 1);

   state_t     state, state_nx;
   logic [7:0] cnt, cnt_nx;
   logic [1:0] op_q, op_nx;
   logic       is_mult;
   logic       is_divm;

   assign is_mult = (op_q == OP_MULT);
   assign is_divm = (op_q == OP_DIVM);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         cnt   <= 8'd0;
         op_q  <= OP_MULT;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         op_q  <= op_nx;
      end
   end

   always_comb begin
      state_nx   = state;
      cnt_nx     = cnt;
      op_nx      = op_q;
      busy       = 1'b0;
      done       = 1'b0;
      div0       = 1'b0;
      mult_ctrl  = 1'b0;
      DIVASelect = 1'b0;
      DIVBSelect = 1'b0;
      RegAWrite  = 1'b0;
      RegBWrite  = 1'b0;
      MDSelect   = 1'b0;
      HiCtrl     = 1'b0;
      LoCtrl     = 1'b0;
      unique case (state)
         IDLE: begin
            if (start && (op != OP_RSVD)) begin
               op_nx    = op;
               state_nx = LOAD;
            end
         end
         LOAD: begin
            busy       = 1'b1;
            mult_ctrl  = is_mult;
            RegAWrite  = !is_mult;
            RegBWrite  = !is_mult;
            DIVASelect = is_divm;
            DIVBSelect = is_divm;
            cnt_nx     = is_mult ? MULT_LD : DIV_LD;
            // divisor is the live DIVBSelect mux output, valid this cycle
            if (!is_mult && (divisor == 32'd0))
               state_nx = EXC;
            else
               state_nx = RUN;
         end
         RUN: begin
            busy       = 1'b1;
            DIVASelect = is_divm;
            DIVBSelect = is_divm;
            MDSelect   = is_mult;
            if (cnt == 8'd0)
               state_nx = WRITE;
            else
               cnt_nx = cnt - 8'd1;
         end
         WRITE: begin
            busy       = 1'b1;
            DIVASelect = is_divm;
            DIVBSelect = is_divm;
            MDSelect   = is_mult;
            HiCtrl     = 1'b1;
            LoCtrl     = 1'b1;
            state_nx   = DONE;
         end
         DONE: begin
            busy     = 1'b1;
            done     = 1'b1;
            state_nx = IDLE;
         end
         EXC: begin
            busy     = 1'b1;
            div0     = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed bench for muldiv_seq.
// Per-cycle output vector check plus completion scoreboard.
module tb_muldiv_seq;

   localparam int MC = 32;
   localparam int DC = 32;

   localparam int B_BUSY = 10;
   localparam int B_DONE = 9;
   localparam int B_DIV0 = 8;
   localparam int B_MC   = 7;
   localparam int B_DA   = 6;
   localparam int B_DB   = 5;
   localparam int B_RA   = 4;
   localparam int B_RB   = 3;
   localparam int B_MD   = 2;
   localparam int B_HI   = 1;
   localparam int B_LO   = 0;

   typedef struct {
      logic kind;
      int   lat;
   } sb_t;

   logic        clk;
   logic        reset;
   logic        start;
   logic [1:0]  op;
   logic [31:0] divisor;
   logic        busy, done, div0, mult_ctrl;
   logic        DIVASelect, DIVBSelect;
   logic        RegAWrite, RegBWrite;
   logic        MDSelect, HiCtrl, LoCtrl;
   logic [10:0] obs;

   int  n_chk;
   int  n_fail;
   sb_t sb[$];

   muldiv_seq #(
      .MULT_CYCLES(MC),
      .DIV_CYCLES (DC)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .op        (op),
      .divisor   (divisor),
      .busy      (busy),
      .done      (done),
      .div0      (div0),
      .mult_ctrl (mult_ctrl),
      .DIVASelect(DIVASelect),
      .DIVBSelect(DIVBSelect),
      .RegAWrite (RegAWrite),
      .RegBWrite (RegBWrite),
      .MDSelect  (MDSelect),
      .HiCtrl    (HiCtrl),
      .LoCtrl    (LoCtrl)
   );

   assign obs = {busy, done, div0, mult_ctrl,
                 DIVASelect, DIVBSelect,
                 RegAWrite, RegBWrite,
                 MDSelect, HiCtrl, LoCtrl};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h",
                tag, got, exp);
      end
   endtask

   // Expected outputs in cycle k after the start edge
   function automatic logic [10:0] exp_vec(input logic [1:0] o,
                                           input logic z,
                                           input int k);
      logic [10:0] v;
      logic        m, dm;
      int          n;
      v  = '0;
      m  = (o == 2'b00);
      dm = (o == 2'b10);
      n  = m ? MC : DC;
      if (o == 2'b11) return v;
      if (!m && z) begin
         if (k == 1) begin
            v[B_BUSY] = 1'b1;
            v[B_RA]   = 1'b1;
            v[B_RB]   = 1'b1;
            v[B_DA]   = dm;
            v[B_DB]   = dm;
         end else if (k == 2) begin
            v[B_BUSY] = 1'b1;
            v[B_DIV0] = 1'b1;
         end
         return v;
      end
      if (k == 1) begin
         v[B_BUSY] = 1'b1;
         v[B_MC]   = m;
         v[B_RA]   = !m;
         v[B_RB]   = !m;
         v[B_DA]   = dm;
         v[B_DB]   = dm;
      end else if (k >= 2 && k <= n + 2) begin
         v[B_BUSY] = 1'b1;
         v[B_DA]   = dm;
         v[B_DB]   = dm;
         v[B_MD]   = m;
         if (k == n + 2) begin
            v[B_HI] = 1'b1;
            v[B_LO] = 1'b1;
         end
      end else if (k == n + 3) begin
         v[B_BUSY] = 1'b1;
         v[B_DONE] = 1'b1;
      end
      return v;
   endfunction

   // rk: cycle to re-pulse start; ak: cycle to assert reset (0 = none)
   task automatic do_req(input logic [1:0] o,
                         input logic [31:0] dv,
                         input int rk,
                         input int ak,
                         input string nm);
      sb_t         e, g;
      int          lat, lim;
      logic        z;
      logic [10:0] ev;
      z   = (dv == 32'd0);
      lat = (o == 2'b11) ? 0 :
            (o != 2'b00 && z) ? 2 :
            ((o == 2'b00) ? MC : DC) + 3;
      if (o != 2'b11) begin
         e.kind = (o != 2'b00) && z;
         e.lat  = lat;
         sb.push_back(e);
      end
      lim = (ak != 0) ? DC + 6 : (o == 2'b11) ? 4 : lat + 1;
      op      = o;
      divisor = dv;
      start   = 1'b1;
      for (int k = 1; k <= lim; k++) begin
         @(posedge clk);
         #1;
         start = (k == rk);
         if (ak != 0 && k == ak) begin
            reset = 1'b0;
            #1;
            e = sb.pop_back();
         end
         if (ak != 0 && k == ak + 2) reset = 1'b1;
         ev = (ak != 0 && k >= ak) ? 11'd0 : exp_vec(o, z, k);
         chk($sformatf("%s vec k=%0d", nm, k), 32'(obs), 32'(ev));
         if (done || div0) begin
            chk($sformatf("%s sb_nonempty k=%0d", nm, k),
                32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
               g = sb.pop_front();
               chk($sformatf("%s completion", nm),
                   {15'd0, div0, 16'(k)},
                   {15'd0, g.kind, 16'(g.lat)});
            end
         end
      end
   endtask

   initial begin
      n_chk   = 0;
      n_fail  = 0;
      reset   = 1'b0;
      start   = 1'b1;
      op      = 2'b00;
      divisor = 32'd0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         chk($sformatf("reset_hold %0d", i), 32'(obs), 32'd0);
      end
      reset = 1'b1;
      do_req(2'b00, 32'd0,   10, 0,  "mult_after_rst");
      do_req(2'b10, 32'd7,   0,  0,  "divm");
      do_req(2'b01, 32'd0,   2,  0,  "div_by_zero");
      do_req(2'b11, 32'd9,   0,  0,  "op_reserved");
      do_req(2'b01, 32'd100, 0,  20, "div_abort");
      do_req(2'b01, 32'd100, 0,  0,  "div_fresh");
      do_req(2'b10, 32'd0,   0,  0,  "divm_zero");
      do_req(2'b00, 32'd3,   0,  0,  "mult_b2b");
      chk("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
